// File: rtl/packet_router_pkg.sv
// Shared types for the packet router: FSM state encoding, drop counter width
// and the header tag range check.
package packet_router_pkg;

    localparam int DROP_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DROP    = 2'd2
    } state_e;

    function automatic logic tag_valid(input logic [31:0] tag, input int unsigned num_ch);
        return tag < num_ch;
    endfunction

endpackage

// File: rtl/packet_router_n_saturating_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count updates on the edge after inc/clr. Backpressure: none.
// Holds at all-ones once reached until cleared or reset.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/packet_router_n.sv
// Steers valid/ready/last packets to one of NUM_CHANNELS outputs by header tag; bad tags dropped and counted.
// Latency: zero cycles, data path is combinational; state/sel/drop_count update on handshake edges.
// Backpressure: ready follows the selected channel's ready_out; always 1 while idle-stripping or dropping.
module packet_router_n
    import packet_router_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int TAG_STRIP    = 1,
    localparam int SEL_W       = $clog2(NUM_CHANNELS)
) (
    input  logic                               clock,
    input  logic                               clear_n,
    input  logic                               valid,
    input  logic [DATA_WIDTH-1:0]              data,
    input  logic                               last,
    output logic                               ready,
    output logic [NUM_CHANNELS-1:0]            valid_out,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CHANNELS-1:0]            last_out,
    input  logic [NUM_CHANNELS-1:0]            ready_out,
    input  logic                               clear_drop_count,
    output logic [DROP_COUNT_WIDTH-1:0]        drop_count,
    output logic [SEL_W-1:0]                   active_channel,
    output logic                               busy
);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  hdr_sel, route_ch;
    logic              tag_ok, route_en, hs, drop_inc;
    logic [NUM_CHANNELS-1:0] sel_hit, ch_rdy;

    assign hdr_sel = data[SEL_W-1:0];
    assign tag_ok  = tag_valid(32'(data), NUM_CHANNELS);
    assign hs      = valid & ready;

    // A kept header is steered before the FSM has latched sel, hence the IDLE route.
    always_comb begin
        route_en = 1'b0;
        route_ch = sel_q;
        case (state_q)
            IDLE: begin
                if ((TAG_STRIP == 0) && tag_ok) begin
                    route_en = 1'b1;
                    route_ch = hdr_sel;
                end
            end
            FORWARD: route_en = 1'b1;
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign sel_hit[i]                          = route_en && (route_ch == SEL_W'(i));
        assign valid_out[i]                        = sel_hit[i] & valid;
        assign last_out[i]                         = sel_hit[i] & last;
        assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = sel_hit[i] ? data : '0;
        assign ch_rdy[i]                           = sel_hit[i] & ready_out[i];
    end

    assign ready = route_en ? |ch_rdy : 1'b1;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        drop_inc = 1'b0;
        if (hs) begin
            case (state_q)
                IDLE: begin
                    if (tag_ok) begin
                        if (!last) begin
                            state_d = FORWARD;
                            sel_d   = hdr_sel;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!last) begin
                            state_d = DROP;
                        end
                    end
                end
                FORWARD, DROP: begin
                    if (last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    saturating_counter #(
        .WIDTH(DROP_COUNT_WIDTH)
    ) u_drop_cnt (
        .clock  (clock),
        .clear_n(clear_n),
        .inc    (drop_inc),
        .clr    (clear_drop_count),
        .count  (drop_count)
    );

    assign busy           = (state_q != IDLE);
    assign active_channel = sel_q;

endmodule

// File: tb/tb_packet_router_n.sv
// Bench for packet_router_n: instance 0 strips the tag, instance 1 keeps it;
// outputs are checked every cycle against per-channel queues of expected beats.
module tb_packet_router_n;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        clr_n [2];
    logic        vld_s [2];
    logic [7:0]  dat_s [2];
    logic        lst_s [2];
    logic [3:0]  rout  [2];
    logic        cdc   [2];
    logic        rdy   [2];
    logic [3:0]  vout  [2];
    logic [31:0] dout  [2];
    logic [3:0]  lout  [2];
    logic [15:0] dcnt  [2];
    logic [1:0]  act   [2];
    logic        bsy   [2];

    packet_router_n #(.NUM_CHANNELS(4), .DATA_WIDTH(8), .TAG_STRIP(1)) dut_strip (
        .clock(clock), .clear_n(clr_n[0]), .valid(vld_s[0]), .data(dat_s[0]), .last(lst_s[0]),
        .ready(rdy[0]), .valid_out(vout[0]), .data_out(dout[0]), .last_out(lout[0]),
        .ready_out(rout[0]), .clear_drop_count(cdc[0]), .drop_count(dcnt[0]),
        .active_channel(act[0]), .busy(bsy[0])
    );

    packet_router_n #(.NUM_CHANNELS(4), .DATA_WIDTH(8), .TAG_STRIP(0)) dut_keep (
        .clock(clock), .clear_n(clr_n[1]), .valid(vld_s[1]), .data(dat_s[1]), .last(lst_s[1]),
        .ready(rdy[1]), .valid_out(vout[1]), .data_out(dout[1]), .last_out(lout[1]),
        .ready_out(rout[1]), .clear_drop_count(cdc[1]), .drop_count(dcnt[1]),
        .active_channel(act[1]), .busy(bsy[1])
    );

    // Expected {last, byte} per (instance*4 + channel), plus delivered counts.
    logic [8:0] expq [8][$];
    int         got  [8];
    int         exp_drops [2];
    int         checks = 0;
    int         errors = 0;
    logic       rand_rdy = 1'b0;

    task automatic monitor();
        logic [7:0] s;
        logic [8:0] e;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                s = dout[d][i*8 +: 8];
                if (vout[d][i] && rout[d][i]) begin
                    checks++;
                    if (expq[d*4+i].size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected inst%0d ch%0d got %h expected no beat", d, i, {lout[d][i], s});
                    end else begin
                        e = expq[d*4+i].pop_front();
                        if ({lout[d][i], s} !== e) begin
                            errors++;
                            $display("FAIL out_beat inst%0d ch%0d got %h expected %h", d, i, {lout[d][i], s}, e);
                        end
                        got[d*4+i]++;
                    end
                end else if (!vout[d][i]) begin
                    checks++;
                    if (s !== 8'h00 || lout[d][i] !== 1'b0) begin
                        errors++;
                        $display("FAIL out_idle inst%0d ch%0d got data %h last %b expected 00 0", d, i, s, lout[d][i]);
                    end
                end
            end
        end
    endtask

    task automatic tick_neg();
        @(negedge clock);
        monitor();
    endtask

    task automatic tick_pos();
        @(posedge clock);
        #1;
        if (rand_rdy) begin
            rout[0] = 4'($urandom);
            rout[1] = 4'($urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick_neg();
            tick_pos();
        end
    endtask

    task automatic drive_beat(input int d, input logic [7:0] b, input logic l, input int budget);
        int   n = 0;
        logic ok = 1'b0;
        vld_s[d] = 1'b1; dat_s[d] = b; lst_s[d] = l;
        forever begin
            tick_neg();
            if (rdy[d]) begin
                ok = 1'b1;
                break;
            end
            if (n >= budget) break;
            n++;
            tick_pos();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake inst%0d data %h: ready low after %0d cycles, required within %0d", d, b, n, budget);
        end
        tick_pos();
        vld_s[d] = 1'b0; dat_s[d] = 8'h00; lst_s[d] = 1'b0;
    endtask

    function automatic void count_drop(input int d);
        if (exp_drops[d] < 65535) exp_drops[d]++;
    endfunction

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            clr_n[d] = 1'b0; vld_s[d] = 1'b0; dat_s[d] = 8'h00; lst_s[d] = 1'b0;
            rout[d] = 4'hF; cdc[d] = 1'b0; exp_drops[d] = 0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        clr_n[0] = 1'b1; clr_n[1] = 1'b1;
        tick_pos();
        for (int d = 0; d < 2; d++) begin
            checks += 7;
            if (rdy[d] !== 1'b1)    begin errors++; $display("FAIL reset_ready inst%0d got %b expected 1", d, rdy[d]); end
            if (bsy[d] !== 1'b0)    begin errors++; $display("FAIL reset_busy inst%0d got %b expected 0", d, bsy[d]); end
            if (act[d] !== 2'd0)    begin errors++; $display("FAIL reset_active inst%0d got %0d expected 0", d, act[d]); end
            if (vout[d] !== 4'h0)   begin errors++; $display("FAIL reset_valid_out inst%0d got %b expected 0000", d, vout[d]); end
            if (dout[d] !== 32'h0)  begin errors++; $display("FAIL reset_data_out inst%0d got %h expected 0", d, dout[d]); end
            if (lout[d] !== 4'h0)   begin errors++; $display("FAIL reset_last_out inst%0d got %b expected 0000", d, lout[d]); end
            if (dcnt[d] !== 16'h0)  begin errors++; $display("FAIL reset_drop_count inst%0d got %h expected 0", d, dcnt[d]); end
        end
    endtask

    task automatic test_strip_forward();
        int g0 = got[2];
        rout[0] = 4'hF;
        expq[2].push_back({1'b0, 8'hAA});
        expq[2].push_back({1'b1, 8'hBB});
        drive_beat(0, 8'h02, 1'b0, 0);
        checks += 2;
        if (bsy[0] !== 1'b1) begin errors++; $display("FAIL strip_busy_hdr got %b expected 1", bsy[0]); end
        if (act[0] !== 2'd2) begin errors++; $display("FAIL strip_active got %0d expected 2", act[0]); end
        drive_beat(0, 8'hAA, 1'b0, 0);
        checks++;
        if (bsy[0] !== 1'b1) begin errors++; $display("FAIL strip_busy_mid got %b expected 1", bsy[0]); end
        drive_beat(0, 8'hBB, 1'b1, 0);
        checks += 2;
        if (bsy[0] !== 1'b0) begin errors++; $display("FAIL strip_busy_end got %b expected 0", bsy[0]); end
        if (got[2] - g0 !== 2) begin errors++; $display("FAIL strip_delivered got %0d beats expected 2", got[2] - g0); end
    endtask

    task automatic test_keep_stall();
        int g0 = got[7];
        rout[1] = 4'b0111;
        expq[7].push_back({1'b0, 8'h03});
        expq[7].push_back({1'b1, 8'h11});
        vld_s[1] = 1'b1; dat_s[1] = 8'h03; lst_s[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_neg();
            checks += 3;
            if (rdy[1] !== 1'b0)          begin errors++; $display("FAIL stall_ready cyc%0d got %b expected 0", k, rdy[1]); end
            if (vout[1] !== 4'b1000)      begin errors++; $display("FAIL stall_valid_out cyc%0d got %b expected 1000", k, vout[1]); end
            if (dout[1] !== 32'h0300_0000) begin errors++; $display("FAIL stall_data_out cyc%0d got %h expected 03000000", k, dout[1]); end
            tick_pos();
        end
        checks++;
        if (bsy[1] !== 1'b0) begin errors++; $display("FAIL stall_busy got %b expected 0", bsy[1]); end
        rout[1] = 4'hF;
        drive_beat(1, 8'h03, 1'b0, 0);
        drive_beat(1, 8'h11, 1'b1, 0);
        checks += 2;
        if (got[7] - g0 !== 2) begin errors++; $display("FAIL stall_delivered got %0d beats expected 2", got[7] - g0); end
        if (bsy[1] !== 1'b0)   begin errors++; $display("FAIL stall_busy_end got %b expected 0", bsy[1]); end
    endtask

    task automatic test_drop();
        rout[0] = 4'hF;
        drive_beat(0, 8'h07, 1'b0, 0);
        count_drop(0);
        checks += 2;
        if (dcnt[0] !== 16'(exp_drops[0])) begin errors++; $display("FAIL drop_count got %0d expected %0d", dcnt[0], exp_drops[0]); end
        if (bsy[0] !== 1'b1) begin errors++; $display("FAIL drop_busy got %b expected 1", bsy[0]); end
        drive_beat(0, 8'h21, 1'b0, 0);
        drive_beat(0, 8'h22, 1'b0, 0);
        drive_beat(0, 8'h23, 1'b1, 0);
        checks += 2;
        if (bsy[0] !== 1'b0) begin errors++; $display("FAIL drop_busy_end got %b expected 0", bsy[0]); end
        if (dcnt[0] !== 16'(exp_drops[0])) begin errors++; $display("FAIL drop_count_end got %0d expected %0d", dcnt[0], exp_drops[0]); end
    endtask

    task automatic test_single_beat();
        int g0 = got[5];
        drive_beat(0, 8'h01, 1'b1, 0);
        checks += 2;
        if (bsy[0] !== 1'b0) begin errors++; $display("FAIL single_busy got %b expected 0", bsy[0]); end
        if (dcnt[0] !== 16'(exp_drops[0])) begin errors++; $display("FAIL single_valid_count got %0d expected %0d", dcnt[0], exp_drops[0]); end
        drive_beat(0, 8'h09, 1'b1, 0);
        count_drop(0);
        checks += 2;
        if (bsy[0] !== 1'b0) begin errors++; $display("FAIL single_bad_busy got %b expected 0", bsy[0]); end
        if (dcnt[0] !== 16'(exp_drops[0])) begin errors++; $display("FAIL single_bad_count got %0d expected %0d", dcnt[0], exp_drops[0]); end
        rout[1] = 4'hF;
        expq[5].push_back({1'b1, 8'h01});
        drive_beat(1, 8'h01, 1'b1, 0);
        checks += 2;
        if (got[5] - g0 !== 1) begin errors++; $display("FAIL single_keep_delivered got %0d expected 1", got[5] - g0); end
        if (bsy[1] !== 1'b0)   begin errors++; $display("FAIL single_keep_busy got %b expected 0", bsy[1]); end
    endtask

    task automatic test_random();
        logic [7:0] b [6];
        int len;
        rand_rdy = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 120; p++) begin
                len  = $urandom_range(1, 5);
                b[0] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
                for (int k = 1; k < 6; k++) b[k] = 8'($urandom);
                if (b[0] < 4) begin
                    for (int k = (d == 0) ? 1 : 0; k < len; k++)
                        expq[d*4 + int'(b[0])].push_back({(k == len - 1), b[k]});
                end else begin
                    count_drop(d);
                end
                for (int k = 0; k < len; k++) drive_beat(d, b[k], (k == len - 1), 60);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rand_rdy = 1'b0;
        rout[0] = 4'hF; rout[1] = 4'hF;
        idle(2);
        for (int q = 0; q < 8; q++) begin
            checks++;
            if (expq[q].size() != 0) begin
                errors++;
                $display("FAIL rand_pending inst%0d ch%0d got %0d undelivered beats expected 0", q / 4, q % 4, expq[q].size());
                expq[q].delete();
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dcnt[d] !== 16'(exp_drops[d])) begin errors++; $display("FAIL rand_drop_count inst%0d got %0d expected %0d", d, dcnt[d], exp_drops[d]); end
        end
    endtask

    task automatic test_reset_mid();
        int g0;
        rout[0] = 4'hF;
        expq[1].push_back({1'b0, 8'h55});
        expq[1].push_back({1'b0, 8'h66});
        drive_beat(0, 8'h01, 1'b0, 0);
        drive_beat(0, 8'h55, 1'b0, 0);
        vld_s[0] = 1'b1; dat_s[0] = 8'h66; lst_s[0] = 1'b0;
        tick_neg();
        checks++;
        if (vout[0] !== 4'b0010) begin errors++; $display("FAIL rst_mid_pre got %b expected 0010", vout[0]); end
        #2;
        clr_n[0] = 1'b0;
        #1;
        exp_drops[0] = 0;
        checks += 4;
        if (vout[0] !== 4'b0000) begin errors++; $display("FAIL rst_mid_valid_out got %b expected 0000", vout[0]); end
        if (bsy[0] !== 1'b0)     begin errors++; $display("FAIL rst_mid_busy got %b expected 0", bsy[0]); end
        if (rdy[0] !== 1'b1)     begin errors++; $display("FAIL rst_mid_ready got %b expected 1", rdy[0]); end
        if (dcnt[0] !== 16'h0)   begin errors++; $display("FAIL rst_mid_count got %0d expected 0", dcnt[0]); end
        vld_s[0] = 1'b0; dat_s[0] = 8'h00;
        tick_pos();
        tick_neg();
        #2;
        clr_n[0] = 1'b1;
        tick_pos();
        g0 = got[0];
        expq[0].push_back({1'b1, 8'h77});
        drive_beat(0, 8'h00, 1'b0, 0);
        checks += 2;
        if (bsy[0] !== 1'b1) begin errors++; $display("FAIL rst_next_busy got %b expected 1", bsy[0]); end
        if (act[0] !== 2'd0) begin errors++; $display("FAIL rst_next_active got %0d expected 0", act[0]); end
        drive_beat(0, 8'h77, 1'b1, 0);
        checks++;
        if (got[0] - g0 !== 1) begin errors++; $display("FAIL rst_next_delivered got %0d expected 1", got[0] - g0); end
    endtask

    task automatic test_saturation();
        vld_s[0] = 1'b1; dat_s[0] = 8'h09; lst_s[0] = 1'b1;
        repeat (65534) @(posedge clock);
        #1;
        checks++;
        if (dcnt[0] !== 16'hFFFE) begin errors++; $display("FAIL sat_below got %h expected fffe", dcnt[0]); end
        @(posedge clock); #1;
        checks++;
        if (dcnt[0] !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h expected ffff", dcnt[0]); end
        @(posedge clock); #1;
        checks++;
        if (dcnt[0] !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h expected ffff", dcnt[0]); end
        cdc[0] = 1'b1;
        @(posedge clock); #1;
        cdc[0] = 1'b0;
        checks++;
        if (dcnt[0] !== 16'h0000) begin errors++; $display("FAIL sat_clear_wins got %h expected 0000", dcnt[0]); end
        @(posedge clock); #1;
        vld_s[0] = 1'b0; dat_s[0] = 8'h00; lst_s[0] = 1'b0;
        checks++;
        if (dcnt[0] !== 16'h0001) begin errors++; $display("FAIL sat_after_clear got %h expected 0001", dcnt[0]); end
    endtask

    initial begin
        for (int q = 0; q < 8; q++) got[q] = 0;
        test_reset();
        test_strip_forward();
        test_keep_stall();
        test_drop();
        test_single_beat();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
